branch_unit_bht: RTL
====================

# branch_unit_bht

Parametrised branch unit for the rvcore execute stage. It resolves the branch condition from raw operands and handles both signed and unsigned compares. It holds a direct-mapped table of 2-bit saturating counters that gives fetch a taken/not-taken prediction, and it updates that table on every resolved branch. It also flags mispredictions and keeps saturating branch/mispredict performance counters.

## Interface
- XLEN, 32, operand and PC width
- BHT_ENTRIES, 64, counter-table depth; power of two, ≥2
- CNT_W, 32, performance counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- pred_pc  in  XLEN  fetch-stage PC to look up
- pred_taken  out  1  prediction for pred_pc (MSB of its counter)
- ex_valid  in  1  execute stage holds a valid instruction
- ex_branch  in  4  bit3 = is-branch, [2:0] = funct3
- ex_pc  in  XLEN  PC of the execute-stage instruction
- ex_rs1, ex_rs2  in  XLEN  compare operands
- ex_pred_taken  in  1  prediction that was made for ex_pc at fetch
- ex_taken  out  1  resolved branch outcome
- ex_mispredict  out  1  resolved outcome differs from ex_pred_taken
- ex_illegal  out  1  ex_valid && bit3 && funct3 ∈ {010,011}
- branch_cnt  out  CNT_W  resolved legal branches
- mispred_cnt  out  CNT_W  mispredicted legal branches

## Operation
- Index: idx(pc) = pc[IDX_W+1:2], where IDX_W = $clog2(BHT_ENTRIES). Compressed/unaligned PCs are out of scope.
- Resolution is combinational. Let br = ex_valid && ex_branch[3] && funct3 legal.
  - 000 BEQ: rs1 == rs2
  - 001 BNE: rs1 != rs2
  - 100 BLT: signed rs1 < rs2
  - 101 BGE: signed rs1 ≥ rs2
  - 110 BLTU: unsigned rs1 < rs2
  - 111 BGEU: unsigned rs1 ≥ rs2
- Resolution outputs:
  - ex_taken = br && condition.
  - ex_mispredict = br && (ex_taken != ex_pred_taken).
  - Illegal funct3 gives ex_taken=0 and ex_mispredict=0, with no table or counter update.
- Table update on clk when br:
  - ex_taken: counter increments, saturating at 11.
  - not taken: counter decrements, saturating at 00.
  - States: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Perf counters on clk:
  - br: branch_cnt += 1.
  - br && ex_mispredict: mispred_cnt += 1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (rst=1 at an edge): every table entry becomes 01, and branch_cnt = mispred_cnt = 0. pred_taken therefore reads 0 for all PCs from the cycle after reset.
- rst held high suppresses all updates; rst has priority over a simultaneous branch.
- pred_taken, ex_taken, ex_mispredict and ex_illegal are combinational, with zero latency.
- A table write is visible to pred_taken one cycle after the update edge.
- Same-cycle read of the entry being written returns the old value; there is no bypass.
- pred_pc and ex_pc aliasing to the same index is legal. Both use that one entry, with old-value semantics for the read.
- Counters are visible on the output the cycle after their update edge.

## Structure
- Shared package rv_branch_pkg holds:
  - funct3 localparams: BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU.
  - the 2-bit counter state encodings, with reset value 2'b01.
- Sub-module bht_counter_table (depth and index width parametrised) contains:
  - the counter array with synchronous reset;
  - a combinational read port;
  - a saturating update port.
- Top level holds the comparator, the mispredict logic and the perf counters.

## Test plan
- Reset, then sweep pred_pc over all indices -> pred_taken=0 everywhere, and branch_cnt=mispred_cnt=0.
- Comparator corners:
  - BLT rs1=0xFFFFFFFF, rs2=1 -> ex_taken=1.
  - BLTU with the same operands -> 0.
  - BGE/BGEU with rs1=rs2=0x80000000 -> 1.
  - BEQ 5,5 -> 1; BNE 5,5 -> 0.
- Three taken BEQs at pc=0x100 with ex_pred_taken=0:
  - pred_taken(0x100) reads 1 after the 1st edge (entry 10), and stays 1 after the 3rd (entry 11, saturated).
  - mispred_cnt=1 if ex_pred_taken tracks pred_taken, else 3.
- Then four not-taken branches at 0x100 -> pred_taken: 1, 0, 0, 0 (entry saturates at 00); branch_cnt increments each cycle.
- Illegal and gated cases:
  - funct3=010 with ex_valid=1 -> ex_illegal=1, ex_taken=0, no counter or table change.
  - ex_valid=0 with ex_branch=4'b1000 -> no update.
- Edge-case races:
  - Branch at pc=0x40 while pred_pc=0x40 -> pred_taken shows the old value in that cycle and the new value next cycle.
  - rst asserted in the same cycle as a branch -> entry 01 and counters 0.
  - With CNT_W=2, after 5 branches -> branch_cnt=3.

Source files
------------

// File: rtl/rv_branch_pkg.sv
// Shared branch-unit definitions: RV32 branch funct3 codes and the 2-bit
// saturating predictor counter encoding with its update rule.
package rv_branch_pkg;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_state_e;

  localparam bht_state_e BHT_RESET = BHT_WNT;

  function automatic bht_state_e bht_next(input bht_state_e cur, input logic taken);
    logic [1:0] raw;
    raw = cur;
    if (taken) begin
      return (cur == BHT_ST) ? BHT_ST : bht_state_e'(raw + 2'd1);
    end
    return (cur == BHT_SNT) ? BHT_SNT : bht_state_e'(raw - 2'd1);
  endfunction

endpackage

// File: rtl/bht_counter_table.sv
// Direct-mapped table of 2-bit saturating counters: one combinational read
// port for fetch, one saturating update port for execute. Reads see old data.
module bht_counter_table
  import rv_branch_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bht_state_e       rd_state_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  bht_state_e cnt_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= BHT_RESET;
      end
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= bht_next(cnt_q[upd_idx_i], upd_taken_i);
    end
  end

  assign rd_state_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_unit_bht.sv
// Execute-stage branch unit: condition resolution, mispredict flag, BHT
// update, and saturating branch/mispredict performance counters.
module branch_unit_bht
  import rv_branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [XLEN-1:0]  pred_pc_i,
  output logic             pred_taken_o,
  input  logic             ex_valid_i,
  input  logic [3:0]       ex_branch_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic [XLEN-1:0]  ex_rs1_i,
  input  logic [XLEN-1:0]  ex_rs2_i,
  input  logic             ex_pred_taken_i,
  output logic             ex_taken_o,
  output logic             ex_mispredict_o,
  output logic             ex_illegal_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [2:0] funct3;
  logic       f3_legal;
  logic       br;
  logic       cond;
  bht_state_e pred_state;

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  assign funct3   = ex_branch_i[2:0];
  assign f3_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
  assign br       = ex_valid_i && ex_branch_i[3] && f3_legal;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      BR_EQ:   cond = (ex_rs1_i == ex_rs2_i);
      BR_NE:   cond = (ex_rs1_i != ex_rs2_i);
      BR_LT:   cond = ($signed(ex_rs1_i) < $signed(ex_rs2_i));
      BR_GE:   cond = ($signed(ex_rs1_i) >= $signed(ex_rs2_i));
      BR_LTU:  cond = (ex_rs1_i < ex_rs2_i);
      BR_GEU:  cond = (ex_rs1_i >= ex_rs2_i);
      default: cond = 1'b0;
    endcase
  end

  assign ex_taken_o      = br && cond;
  assign ex_mispredict_o = br && (ex_taken_o != ex_pred_taken_i);
  assign ex_illegal_o    = ex_valid_i && ex_branch_i[3] && !f3_legal;

  bht_counter_table #(
    .DEPTH (BHT_ENTRIES),
    .IDX_W (IDX_W)
  ) u_table (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_idx_i    (pred_pc_i[IDX_W+1:2]),
    .rd_state_o  (pred_state),
    .upd_en_i    (br),
    .upd_idx_i   (ex_pc_i[IDX_W+1:2]),
    .upd_taken_i (ex_taken_o)
  );

  assign pred_taken_o = pred_state[1];

  // Counters stick at all-ones so long runs never wrap back to small values.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (br && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + 1'b1;
    end
    if (ex_mispredict_o && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{pred_pc_i[XLEN-1:IDX_W+2], pred_pc_i[1:0],
                         ex_pc_i[XLEN-1:IDX_W+2], ex_pc_i[1:0], pred_state[0]};

endmodule
